// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream into 32-bit words and writes them to instruction memory.
// Optional running checksum of written words when IMEM_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int ADDR_W  = 8,
  parameter int BYTE_LE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              pc_enable,
  output logic              pc_reset_out,
  output logic              busy,
  output logic              done,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_R = 1;
  localparam logic [ADDR_W-1:0] ONE_A = 1;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   remain_q, remain_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       word_q, word_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              pc_reset_q, pc_reset_d;
  logic              done_q, done_d;

  logic [ADDR_W:0]   n_clamp;
  logic              xfer;
  logic              last_byte;
  logic [1:0]        lane;

  assign n_clamp   = (word_count > DEPTH) ? DEPTH : word_count;
  assign xfer      = byte_valid & byte_ready;
  assign last_byte = xfer & (bcnt_q == 2'd3);
  assign lane      = (BYTE_LE != 0) ? bcnt_q : ~bcnt_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && n_clamp != '0) state_d = COLLECT;
      COLLECT: if (last_byte) state_d = WRITE;
      WRITE:   state_d = (remain_q == ONE_R) ? RELEASE : COLLECT;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: counters, word address and the word being assembled
  always_comb begin
    remain_d = remain_q;
    waddr_d  = waddr_q;
    bcnt_d   = bcnt_q;
    word_d   = word_q;
    if (state_q == IDLE && start) begin
      remain_d = n_clamp;
      waddr_d  = '0;
      bcnt_d   = '0;
    end
    if (state_q == COLLECT && xfer) begin
      word_d[{lane, 3'b000} +: 8] = byte_in;
      bcnt_d = bcnt_q + 2'd1;
    end
    if (state_q == WRITE) begin
      waddr_d  = waddr_q + ONE_A;
      remain_d = remain_q - ONE_R;
      bcnt_d   = '0;
    end
  end

  // Output decode and next values of the registered outputs
  always_comb begin
    byte_ready  = (state_q == COLLECT);
    busy        = (state_q != IDLE);
    pc_enable   = (state_q == IDLE);
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pc_reset_d  = (state_q == WRITE) && (remain_q == ONE_R);
    done_d      = (state_q == RELEASE) ||
                  (state_q == IDLE && start && n_clamp == '0);
    if (state_q == COLLECT && last_byte) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = {{(30-ADDR_W){1'b0}}, waddr_q, 2'b00};
      mem_wdata_d = word_d;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remain_q    <= '0;
      waddr_q     <= '0;
      bcnt_q      <= '0;
      word_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      pc_reset_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      remain_q    <= remain_d;
      waddr_q     <= waddr_d;
      bcnt_q      <= bcnt_d;
      word_q      <= word_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      pc_reset_q  <= pc_reset_d;
      done_q      <= done_d;
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign pc_reset_out = pc_reset_q;
  assign done         = done_q;

`ifdef IMEM_CHECKSUM_EN
  logic [31:0] sum_q;

  // Running sum of written words, cleared when a load is requested
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           sum_q <= '0;
    else if (state_q == IDLE && start)   sum_q <= '0;
    else if (mem_we_q)                   sum_q <= sum_q + mem_wdata_q;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule
